// File: rtl/tdc_event_reader.sv
// tdc_event_reader: consumer side of the TDC hasEvent/clear handshake, buffering
// captured events in a first-word-fall-through FIFO with sticky drop tracking.
module tdc_event_reader #(
  parameter int DEPTH = 4,
  parameter logic [3:0] CHAN_ID = 4'h0,
  parameter int CLR_RETRY = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enable,
  output logic                     o_enable_channel,
  input  logic                     i_hasEvent,
  input  logic                     i_busy,
  input  logic [31:0]              i_timestamp,
  input  logic [31:0]              i_pulseWidth,
  output logic                     o_clear,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [67:0]              o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  input  logic                     i_overflow_clr,
  output logic [7:0]               o_drop_count,
  output logic                     o_busy_seen
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(CLR_RETRY) + 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [RW-1:0] RETRY_LAST = RW'(CLR_RETRY - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_LOW} state_t;
  state_t        r_state;
  logic [RW-1:0] r_retry;
  logic [67:0]   r_mem [DEPTH];
  logic [67:0]   r_last;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic [7:0]    r_drop;
  logic          w_req;
  logic          w_pop;
  logic          w_acc;
  logic          w_drop;
  assign w_req = (r_state == IDLE) && i_enable && i_hasEvent;
  assign w_pop = o_valid && i_ready;
  assign w_acc = w_req && (r_count != FULL || w_pop);
  assign w_drop = w_req && !w_acc;
  assign o_valid = r_count != '0;
  assign o_count = r_count;
  assign o_drop_count = r_drop;
  // r_last keeps the most recently popped word so o_data is stable while empty
  assign o_data = o_valid ? r_mem[r_rd] : r_last;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      o_clear <= 1'b0;
      r_retry <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            o_clear <= 1'b1;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          o_clear <= 1'b0;
          r_retry <= '0;
          r_state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!i_hasEvent) begin
            r_state <= IDLE;
          end else if (r_retry == RETRY_LAST) begin
            o_clear <= 1'b1;
            r_state <= CLEAR;
          end else begin
            r_retry <= r_retry + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      r_wr    <= w_acc ? r_wr + 1'b1 : r_wr;
      r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
      r_last  <= w_pop ? r_mem[r_rd] : r_last;
      r_count <= (w_acc && !w_pop) ? r_count + 1'b1 :
                 (!w_acc && w_pop) ? r_count - 1'b1 : r_count;
    end
  end
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wr] <= {CHAN_ID, i_pulseWidth, i_timestamp};
  end
  // a drop on the same edge as a clear request wins and restarts the count at 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_enable_channel <= 1'b0;
      o_busy_seen      <= 1'b0;
      o_overflow       <= 1'b0;
      r_drop           <= '0;
    end else begin
      o_enable_channel <= i_enable;
      o_busy_seen      <= i_busy;
      o_overflow       <= w_drop ? 1'b1 : i_overflow_clr ? 1'b0 : o_overflow;
      r_drop           <= w_drop ? (i_overflow_clr ? 8'd1 : (r_drop == 8'hFF ? r_drop : r_drop + 1'b1)) :
                          i_overflow_clr ? 8'd0 : r_drop;
    end
  end
endmodule

// File: doc/tdc_event_reader.md
Name:
tdc_event_reader

Overview:
- Consumer side of the TDC channel handshake.
- Watches the TDC's hasEvent flag and captures the timestamp and pulse width into a small first-word-fall-through FIFO.
- Pulses clear back to the TDC, then presents captured events to downstream readout logic over a valid/ready interface.
- Drives the TDC channel enable and tracks dropped events.

Parameters:
- DEPTH, 4: FIFO entries (power of 2, at least 2).
- CHAN_ID, 4'h0: channel identifier prepended to each event word.
- CLR_RETRY, 16: cycles spent in WAIT_LOW before clear is re-pulsed.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- i_enable  in  1  software channel enable.
- o_enable_channel  out  1  enable to TDC; i_enable registered once.
- i_hasEvent  in  1  TDC event-ready flag.
- i_busy  in  1  TDC measurement in progress (status only).
- i_timestamp  in  32  TDC timestamp.
- i_pulseWidth  in  32  TDC time-over-threshold.
- o_clear  out  1  single-cycle clear pulse to TDC.
- o_valid  out  1  FIFO head valid.
- i_ready  in  1  downstream accepts head.
- o_data  out  68  {CHAN_ID[3:0], TOT[31:0], TS[31:0]} at FIFO head.
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_overflow  out  1  sticky drop flag.
- i_overflow_clr  in  1  clears o_overflow and o_drop_count.
- o_drop_count  out  8  dropped events, saturating.
- o_busy_seen  out  1  i_busy registered once (status).

Behaviour:
- Reset (async, any time, including mid-handshake):
  - state=IDLE; FIFO pointers and o_count = 0.
  - o_valid=0, o_clear=0, o_enable_channel=0, o_overflow=0, o_drop_count=0, o_busy_seen=0, o_data=0.
- FSM states: IDLE, CLEAR, WAIT_LOW.
- IDLE:
  - At an edge where i_enable=1 and i_hasEvent=1: capture {CHAN_ID, i_pulseWidth, i_timestamp}, set o_clear<=1, go to CLEAR.
  - With i_enable=0, i_hasEvent is ignored; the FIFO still drains.
- Capture accept rule: push is accepted if o_count<DEPTH, or if a pop occurs on the same edge.
  - On accept: entry is written, and o_valid is high in the next cycle if the FIFO was empty. Capture-to-o_valid latency is 1 cycle.
  - On reject: event is dropped; o_overflow<=1; o_drop_count increments and saturates at 255; o_clear is still pulsed.
- CLEAR:
  - o_clear is high for exactly this one cycle.
  - Next edge: o_clear<=0 and a retry counter loads 0; go to WAIT_LOW.
- WAIT_LOW:
  - If i_hasEvent=0: go to IDLE. A new event can be captured no earlier than 3 cycles after the previous capture edge.
  - If i_hasEvent is still 1 when the retry counter reaches CLR_RETRY-1: o_clear<=1, go to CLEAR.
  - A retry never re-captures data.
- FIFO:
  - First-word-fall-through; o_data is driven from the head register.
  - o_valid = (o_count != 0).
  - Pop when o_valid && i_ready.
  - Simultaneous push and pop: o_count is unchanged.
  - Pointers wrap modulo DEPTH.
  - o_data holds its last value when the FIFO is empty.
- i_overflow_clr:
  - Synchronous; clears o_overflow and o_drop_count.
  - If a drop occurs on the same edge, the drop wins: o_overflow=1, o_drop_count=1.
- o_enable_channel follows i_enable with 1 cycle of latency.
- Disabling the channel mid-handshake does not abort CLEAR or WAIT_LOW.

Test Plan:
- Reset, then i_enable=1 -> o_enable_channel=1 one cycle later; all other outputs 0.
- Single event: i_hasEvent rises with TS=32'h0000_1234, TOT=32'h0000_0050, i_ready=0 -> next cycle o_valid=1, o_data=68'h0_00000050_00001234, o_clear=1 for 1 cycle, o_count=1.
- Four back-to-back events with i_ready=0 (DEPTH=4), then a 5th -> o_count=4, o_overflow=1, o_drop_count=1, o_clear still pulsed; asserting i_ready then drains the 4 entries in order.
- Full FIFO, 5th event captured on the same edge as a pop -> no drop, o_count stays 4, the new entry is last out.
- TDC ignores clear and holds i_hasEvent=1 -> o_clear re-pulses every CLR_RETRY+1 cycles; o_count increments only once.
- Async reset asserted in CLEAR with o_count=2 -> o_clear, o_valid, o_count all go to 0 immediately; after release, reads occur only after a fresh event.
